mc_ctrl_hs: RTL and testbench

Parametrised successor to the multi-cycle MIPS control FSM.
- Adds a memory ready/ack handshake, so the shared instruction/data memory may take a variable number of cycles.
- Adds a single-step mode driven by the debounced button pulse.
- Adds ack-timeout and illegal-opcode error trapping, plus a retired-instruction counter for the display mux.
- Drives the existing datapath mux/enable signals in the CPU top.

---
 rtl/mc_ctrl_hs.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with a memory ready/ack handshake, single-step mode,
// ack-timeout / illegal-opcode trapping and a retired-instruction counter.
module mc_ctrl_hs #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_mode,
  input  logic             go,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUsrcA,
  output logic             IorD,
  output logic             IRwrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             PCWriteCond,
  output logic             PCwrite,
  output logic             BranchNe,
  output logic [1:0]       ALUop,
  output logic [1:0]       ALUsrcB,
  output logic [1:0]       PCsrc,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [1:0]       err_code
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_IDLE   = 4'd12,
    S_ERR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              retire;
  logic              timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The cycle that reaches the limit still honours mem_ack; only a missing ack traps.
  assign timeout = mem_req && !mem_ack && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!step_mode || go) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_IEXEC;
          default: begin
            state_d = S_ERR;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ack) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_MEMWR: begin
        if (mem_ack) begin
          retire = 1'b1;
        end else if (timeout) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_EXEC:  state_d = S_RWB;
      S_IEXEC: state_d = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: retire = 1'b1;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    if (retire) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = step_mode ? S_IDLE : S_FETCH;
    end
  end

  // Wait counter restarts whenever the state changes, so every memory state begins at zero.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_req && !mem_ack) begin
      wait_d = wait_q + TO_W'(1);
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUsrcA     = 1'b0;
    IorD        = 1'b0;
    IRwrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    PCWriteCond = 1'b0;
    PCwrite     = 1'b0;
    BranchNe    = 1'b0;
    ALUop       = 2'b00;
    ALUsrcB     = 2'b00;
    PCsrc       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        IRwrite = mem_ack;
        PCwrite = mem_ack;
      end
      S_DECODE: ALUsrcB = 2'b11;
      S_MEMADR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_EXEC: begin
        ALUsrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCsrc       = 2'b01;
        BranchNe    = (opcode == OP_BNE);
      end
      S_JUMP: begin
        PCwrite = 1'b1;
        PCsrc   = 2'b10;
      end
      S_IEXEC: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
      end
      S_IWB:   RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state      = state_q;
  assign instr_done = retire;
  assign instr_cnt  = cnt_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: instruction traces, handshake stalls, timeout,
// single-step, illegal opcode, mid-access reset and counter wrap.
module tb_mc_ctrl_hs;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, step_mode, go, mem_ack;
  logic [5:0]       opcode;
  logic             mem_req, RegDst, RegWrite, ALUsrcA, IorD, IRwrite, MemRead, MemWrite;
  logic             MemToReg, PCWriteCond, PCwrite, BranchNe, instr_done;
  logic [1:0]       ALUop, ALUsrcB, PCsrc, err_code;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic [17:0]      ctrl;

  int n_chk  = 0;
  int n_pass = 0;

  mc_ctrl_hs #(.MEM_TIMEOUT(4), .TO_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .step_mode(step_mode), .go(go), .opcode(opcode),
    .mem_ack(mem_ack), .mem_req(mem_req), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUsrcA(ALUsrcA), .IorD(IorD), .IRwrite(IRwrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .PCWriteCond(PCWriteCond),
    .PCwrite(PCwrite), .BranchNe(BranchNe), .ALUop(ALUop), .ALUsrcB(ALUsrcB),
    .PCsrc(PCsrc), .state(state), .instr_done(instr_done), .instr_cnt(instr_cnt),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  assign ctrl = {mem_req, RegDst, RegWrite, ALUsrcA, IorD, IRwrite, MemRead, MemWrite,
                 MemToReg, PCWriteCond, PCwrite, BranchNe, ALUop, ALUsrcB, PCsrc};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Control outputs each state should drive, written out from the state table.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic ack,
                                           input logic [5:0] op);
    logic mreq, rdst, rw, asa, iord, irw, mr, mw, m2r, pcc, pcw, bne;
    logic [1:0] aop, asb, pcs;
    {mreq, rdst, rw, asa, iord, irw, mr, mw, m2r, pcc, pcw, bne} = '0;
    aop = 2'b00; asb = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin mreq = 1; mr = 1; asb = 2'b01; irw = ack; pcw = ack; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mreq = 1; mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mreq = 1; mw = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; bne = (op == 6'b000101); end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {mreq, rdst, rw, asa, iord, irw, mr, mw, m2r, pcc, pcw, bne, aop, asb, pcs};
  endfunction

  // trace holds up to five state codes, first state in the low nibble; no clock after the last.
  task automatic run_trace(input string name, input logic [5:0] op, input int len,
                           input logic [19:0] trace);
    logic [3:0] st;
    opcode = op;
    for (int i = 0; i < len; i++) begin
      st = trace[i*4 +: 4];
      chk({name, "_state"}, state, st);
      chk({name, "_ctrl"}, ctrl, exp_ctrl(st, mem_ack, op));
      chk({name, "_done"}, instr_done, (i == len - 1));
      if (i < len - 1) cyc();
    end
  endtask

  initial begin
    rst = 1'b0; step_mode = 1'b0; go = 1'b0; mem_ack = 1'b1; opcode = 6'h00;
    cyc(); cyc();
    chk("reset_state", state, 4'd12);
    chk("reset_cnt", instr_cnt, 0);
    chk("reset_err", err_code, 2'b00);
    chk("reset_ctrl", ctrl, 18'h0);
    chk("reset_done", instr_done, 1'b0);

    rst = 1'b1;
    cyc();
    run_trace("rtype", 6'b000000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0});  cyc();
    run_trace("lw",    6'b100011, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0});  cyc();
    run_trace("sw",    6'b101011, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0});  cyc();
    run_trace("beq",   6'b000100, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0});  cyc();
    run_trace("j",     6'b000010, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0});  cyc();
    run_trace("addi",  6'b001000, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0});
    mem_ack = 1'b0;
    cyc();
    chk("cnt_after_six", instr_cnt, 6);

    // Fetch stalls three cycles; the ack arrives in the cycle the limit is reached.
    for (int i = 0; i < 3; i++) begin
      chk("stall_state", state, 4'd0);
      chk("stall_req", mem_req, 1'b1);
      chk("stall_irw", IRwrite, 1'b0);
      chk("stall_pcw", PCwrite, 1'b0);
      cyc();
    end
    mem_ack = 1'b1;
    #1;
    chk("ack_state", state, 4'd0);
    chk("ack_irw", IRwrite, 1'b1);
    chk("ack_pcw", PCwrite, 1'b1);
    cyc();
    run_trace("bne", 6'b000101, 2, {4'd0, 4'd0, 4'd0, 4'd8, 4'd1});
    cyc();
    chk("cnt_seven", instr_cnt, 7);

    // Read that never gets an ack traps after four wait cycles.
    opcode = 6'b100011;
    cyc(); cyc();
    chk("to_memadr", state, 4'd2);
    mem_ack = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_state", state, 4'd3);
      chk("to_wait_req", mem_req, 1'b1);
      chk("to_wait_regwr", RegWrite, 1'b0);
      cyc();
    end
    chk("to_err_state", state, 4'd15);
    chk("to_err_code", err_code, 2'b01);
    chk("to_err_ctrl", ctrl, 18'h0);
    chk("to_err_cnt", instr_cnt, 7);
    mem_ack = 1'b1; go = 1'b1; step_mode = 1'b0;
    cyc(); cyc();
    go = 1'b0;
    chk("err_sticky", state, 4'd15);
    chk("err_sticky_cnt", instr_cnt, 7);
    rst = 1'b0;
    #1;
    chk("err_prereset", state, 4'd15);
    cyc();
    chk("err_reset_state", state, 4'd12);
    chk("err_reset_code", err_code, 2'b00);
    chk("err_reset_cnt", instr_cnt, 0);
    rst = 1'b1;

    // Ack on the fourth wait cycle of a read is accepted.
    cyc();
    chk("edge_fetch", state, 4'd0);
    cyc(); cyc();
    mem_ack = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("edge_wait", state, 4'd3);
      cyc();
    end
    mem_ack = 1'b1;
    #1;
    chk("edge_ack_state", state, 4'd3);
    cyc();
    chk("edge_memwb", state, 4'd4);
    chk("edge_done", instr_done, 1'b1);
    step_mode = 1'b1;
    cyc();
    chk("step_idle", state, 4'd12);
    chk("step_cnt1", instr_cnt, 1);

    // Single-step: one instruction per go, go during EXEC ignored.
    for (int i = 0; i < 10; i++) begin
      chk("step_wait_idle", state, 4'd12);
      cyc();
    end
    opcode = 6'b000000;
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("step_fetch", state, 4'd0);
    cyc();
    chk("step_decode", state, 4'd1);
    cyc();
    chk("step_exec", state, 4'd6);
    go = 1'b1;
    cyc();
    go = 1'b0;
    chk("step_rwb", state, 4'd7);
    chk("step_rwb_done", instr_done, 1'b1);
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("step_back_idle", state, 4'd12);
      chk("step_idle_done", instr_done, 1'b0);
      cyc();
    end
    chk("step_cnt2", instr_cnt, 2);

    // Illegal opcode.
    opcode = 6'b111111;
    go = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    chk("ill_decode", state, 4'd1);
    cyc();
    chk("ill_state", state, 4'd15);
    chk("ill_code", err_code, 2'b10);
    chk("ill_cnt", instr_cnt, 2);
    cyc();
    chk("ill_sticky", state, 4'd15);

    // Reset during a stalled store.
    rst = 1'b0;
    cyc();
    rst = 1'b1; step_mode = 1'b0; mem_ack = 1'b1; opcode = 6'b101011;
    cyc(); cyc(); cyc();
    chk("wr_memadr", state, 4'd2);
    mem_ack = 1'b0;
    cyc();
    chk("wr_state", state, 4'd5);
    chk("wr_ctrl", ctrl, exp_ctrl(4'd5, 1'b0, opcode));
    chk("wr_done", instr_done, 1'b0);
    cyc();
    chk("wr_hold_memwrite", MemWrite, 1'b1);
    rst = 1'b0;
    #1;
    chk("wr_prereset_req", mem_req, 1'b1);
    cyc();
    chk("wr_reset_state", state, 4'd12);
    chk("wr_reset_req", mem_req, 1'b0);
    chk("wr_reset_cnt", instr_cnt, 0);

    // Sixteen jumps wrap the 4-bit counter back to zero.
    rst = 1'b1; mem_ack = 1'b1; opcode = 6'b000010;
    cyc();
    for (int i = 1; i <= 16; i++) begin
      cyc(); cyc(); cyc();
      chk("wrap_cnt", instr_cnt, i % 16);
      chk("wrap_state", state, 4'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
